// File: rtl/gain_pkg.sv
// Shared types and constant helpers for the per-channel gain stage.
package gain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    function automatic logic [63:0] unity(input int gain_w, input int gain_int);
        return 64'd1 << (gain_w - gain_int);
    endfunction

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/channel_gain_if.sv
// Sample, gain-config and status bundle of the channel gain stage.
interface channel_gain_if #(
    parameter int N_CH     = 8,
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 24
);
    localparam int AW = $clog2(N_CH);

    logic                           data_request;
    logic [N_CH-1:0][SAMPLE_W-1:0]  audio_in;
    logic [N_CH-1:0][SAMPLE_W-1:0]  audio_out;
    logic                           cfg_wr;
    logic [AW-1:0]                  cfg_addr;
    logic [GAIN_W-1:0]              cfg_data;
    logic                           busy;
    logic                           done;
    logic                           overrun;
    logic [N_CH-1:0]                clip;

    modport master (
        output data_request, audio_in, cfg_wr, cfg_addr, cfg_data,
        input  audio_out, busy, done, overrun, clip
    );

    modport slave (
        input  data_request, audio_in, cfg_wr, cfg_addr, cfg_data,
        output audio_out, busy, done, overrun, clip
    );

endinterface

// File: rtl/gain_mul_sat.sv
// One-stage signed x unsigned gain multiply with floor shift and saturation.
module gain_mul_sat
    import gain_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 24,
    parameter int GAIN_INT = 2,
    parameter int CH_W     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [CH_W-1:0]            in_ch,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic [GAIN_W-1:0]          gain,
    output logic                       out_valid,
    output logic [CH_W-1:0]            out_ch,
    output logic [SAMPLE_W-1:0]        result,
    output logic                       sat
);
    localparam int FRAC = GAIN_W - GAIN_INT;
    localparam int P    = SAMPLE_W + GAIN_W + 1;
    localparam longint MAX = sat_max(SAMPLE_W);
    localparam longint MIN = sat_min(SAMPLE_W);

    logic signed [P-1:0] a, b, prod_q, shifted;

    assign a = P'(sample);
    assign b = P'({1'b0, gain});

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            prod_q    <= '0;
        end else begin
            out_valid <= in_valid;
            out_ch    <= in_ch;
            prod_q    <= a * b;
        end
    end

    // Arithmetic shift floors toward -inf
    assign shifted = prod_q >>> FRAC;

    always_comb begin
        result = shifted[SAMPLE_W-1:0];
        sat    = 1'b0;
        if (longint'(shifted) > MAX) begin
            result = SAMPLE_W'(MAX);
            sat    = 1'b1;
        end else if (longint'(shifted) < MIN) begin
            result = SAMPLE_W'(MIN);
            sat    = 1'b1;
        end
    end

endmodule

// File: rtl/channel_gain.sv
// Frame-strobed per-channel gain with double-buffered gains and clip flags.
module channel_gain
    import gain_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int SAMPLE_W = 24,
    parameter int GAIN_W   = 24,
    parameter int GAIN_INT = 2
) (
    input  logic           clk,
    input  logic           reset,
    channel_gain_if.slave  bus
);
    localparam int AW = $clog2(N_CH);
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity(GAIN_W, GAIN_INT));
    localparam logic [AW-1:0] LAST = AW'(N_CH - 1);

    logic [GAIN_W-1:0]             shadow [N_CH];
    logic [GAIN_W-1:0]             active [N_CH];
    logic [N_CH-1:0][SAMPLE_W-1:0] snap;
    state_t                        state_q, state_d;
    logic [AW-1:0]                 idx_q;
    logic [N_CH-1:0]               acc_q, acc_d;
    logic                          accept, issue, fin;
    logic                          mv, msat;
    logic [AW-1:0]                 mch;
    logic [SAMPLE_W-1:0]           mres;

    assign accept = bus.data_request && !bus.busy;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE:  if (accept) state_d = RUN;
            RUN: begin
                issue = 1'b1;
                if (idx_q == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (mv && msat) acc_d[mch] = 1'b1;
    end

    gain_mul_sat #(
        .SAMPLE_W (SAMPLE_W),
        .GAIN_W   (GAIN_W),
        .GAIN_INT (GAIN_INT),
        .CH_W     (AW)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue),
        .in_ch     (idx_q),
        .sample    ($signed(snap[idx_q])),
        .gain      (active[idx_q]),
        .out_valid (mv),
        .out_ch    (mch),
        .result    (mres),
        .sat       (msat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            snap          <= '0;
            bus.audio_out <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.clip      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= UNITY;
                active[i] <= UNITY;
            end
        end else begin
            state_q     <= state_d;
            bus.done    <= fin;
            bus.overrun <= bus.data_request && bus.busy;
            if (bus.cfg_wr && int'(bus.cfg_addr) < N_CH)
                shadow[bus.cfg_addr] <= bus.cfg_data;
            // Active bank takes the pre-edge shadow, so same-edge writes wait a frame
            if (accept) begin
                snap     <= bus.audio_in;
                bus.busy <= 1'b1;
                idx_q    <= '0;
                acc_q    <= '0;
                for (int i = 0; i < N_CH; i++) active[i] <= shadow[i];
            end else begin
                if (issue) idx_q <= idx_q + AW'(1);
                acc_q <= acc_d;
            end
            if (mv) bus.audio_out[mch] <= mres;
            if (fin) begin
                bus.busy <= 1'b0;
                bus.clip <= acc_d;
            end
        end
    end

endmodule

// File: tb/tb_channel_gain.sv
// Scoreboard bench for channel_gain: frames queued at request, checked at done.
module tb_channel_gain;

    localparam int N  = 8;
    localparam int SW = 24;
    localparam int GW = 24;

    typedef logic [N-1:0][SW-1:0] vec_t;
    typedef struct {
        vec_t            out;
        logic [N-1:0]    clip;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    channel_gain_if #(.N_CH(N), .SAMPLE_W(SW), .GAIN_W(GW)) ifc ();

    channel_gain #(
        .N_CH     (N),
        .SAMPLE_W (SW),
        .GAIN_W   (GW),
        .GAIN_INT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int     nvec = 0;
    int     nbad = 0;
    frame_t exp_q[$];

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vec_t fill(input logic [SW-1:0] v);
        vec_t r;
        for (int k = 0; k < N; k++) r[k] = v;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && ifc.busy; i++) step();
        check("frame_end_busy", ifc.busy, 1'b0);
    endtask

    task automatic run_frame(input vec_t in, input vec_t eo,
                             input logic [N-1:0] ec);
        frame_t f;
        f.out  = eo;
        f.clip = ec;
        ifc.audio_in     = in;
        ifc.data_request = 1'b1;
        exp_q.push_back(f);
        step();
        ifc.data_request = 1'b0;
        ifc.cfg_wr       = 1'b0;
        wait_idle();
    endtask

    task automatic write_gain(input int ch, input logic [GW-1:0] g);
        ifc.cfg_wr   = 1'b1;
        ifc.cfg_addr = 3'(ch);
        ifc.cfg_data = g;
        step();
        ifc.cfg_wr   = 1'b0;
    endtask

    // Scoreboard monitor: a done pulse retires one queued frame
    always @(negedge clk) begin
        if (!reset && ifc.done === 1'b1) begin
            frame_t f;
            if (exp_q.size() == 0) begin
                nvec++;
                nbad++;
                $display("FAIL unexpected_done: got done=1, want no frame");
            end else begin
                f = exp_q.pop_front();
                for (int k = 0; k < N; k++)
                    check($sformatf("frame_out[%0d]", k), ifc.audio_out[k], f.out[k]);
                check("frame_clip", ifc.clip, f.clip);
            end
        end
    end

    initial begin
        #100000;
        nbad++;
        $display("FAIL watchdog: got timeout, want finish");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t in, eo, ev, ina, inb, eoa, eob;

        reset            = 1'b1;
        ifc.data_request = 1'b0;
        ifc.audio_in     = '0;
        ifc.cfg_wr       = 1'b0;
        ifc.cfg_addr     = '0;
        ifc.cfg_data     = '0;
        step();
        step();
        reset = 1'b0;

        check("rst_out", ifc.audio_out, '0);
        check("rst_busy", ifc.busy, 1'b0);
        check("rst_done", ifc.done, 1'b0);
        check("rst_overrun", ifc.overrun, 1'b0);
        check("rst_clip", ifc.clip, '0);

        // Unity frame with per-edge timing
        ifc.audio_in     = fill(24'h100000);
        ifc.data_request = 1'b1;
        exp_q.push_back('{fill(24'h100000), '0});
        step();
        ifc.data_request = 1'b0;
        check("busy_e0", ifc.busy, 1'b1);
        for (int e = 1; e <= 9; e++) begin
            step();
            for (int k = 0; k < N; k++) ev[k] = (e >= k + 2) ? 24'h100000 : 24'h0;
            check($sformatf("out_e%0d", e), ifc.audio_out, ev);
            check($sformatf("busy_e%0d", e), ifc.busy, (e <= 8));
            check($sformatf("done_e%0d", e), ifc.done, (e == 9));
        end

        // Gain write: ch3 = 0.5
        write_gain(3, 24'h200000);
        eo    = fill(24'h100000);
        eo[3] = 24'h080000;
        run_frame(fill(24'h100000), eo, '0);
        in    = fill(24'h100000);
        in[3] = 24'hFFFFFF;
        eo[3] = 24'hFFFFFF;
        run_frame(in, eo, '0);

        // Saturation: ch0 = 3.0
        write_gain(0, 24'hC00000);
        in    = fill(24'h100000);
        in[0] = 24'h400000;
        eo    = fill(24'h100000);
        eo[3] = 24'h080000;
        eo[0] = 24'h7FFFFF;
        run_frame(in, eo, 8'h01);
        check("clip_hold", ifc.clip, 8'h01);
        in[0] = 24'hC00000;
        eo[0] = 24'h800000;
        run_frame(in, eo, 8'h01);
        in[0] = 24'h100000;
        eo[0] = 24'h300000;
        run_frame(in, eo, '0);

        // Overrun at edges 4 and 9, accept at 10
        ina    = fill(24'h100000);
        eoa    = fill(24'h100000);
        eoa[0] = 24'h300000;
        eoa[3] = 24'h080000;
        inb    = fill(24'h010000);
        eob    = fill(24'h010000);
        eob[0] = 24'h030000;
        eob[3] = 24'h008000;
        for (int e = 0; e <= 10; e++) begin
            ifc.audio_in     = (e == 10) ? inb : ina;
            ifc.data_request = (e == 0 || e == 4 || e == 9 || e == 10);
            if (e == 0)  exp_q.push_back('{eoa, '0});
            if (e == 10) exp_q.push_back('{eob, '0});
            step();
            ifc.data_request = 1'b0;
            check($sformatf("ovr_e%0d", e), ifc.overrun, (e == 4 || e == 9));
            if (e == 10) check("accept_e10", ifc.busy, 1'b1);
        end
        wait_idle();

        // Same-edge write lands in shadow only
        ifc.cfg_wr   = 1'b1;
        ifc.cfg_addr = 3'd1;
        ifc.cfg_data = 24'h0;
        run_frame(fill(24'h100000), eoa, '0);
        eo    = eoa;
        eo[1] = 24'h0;
        run_frame(fill(24'h100000), eo, '0);

        // Reset at edge 3 mid-frame
        ifc.audio_in     = ina;
        ifc.data_request = 1'b1;
        step();
        ifc.data_request = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_out", ifc.audio_out, '0);
        check("midrst_busy", ifc.busy, 1'b0);
        check("midrst_clip", ifc.clip, '0);
        repeat (12) step();
        check("midrst_idle", ifc.busy, 1'b0);
        run_frame(ina, fill(24'h100000), '0);

        step();
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
